// File: rtl/m1resetctl_pkg.sv
// rtl/m1resetctl_pkg.sv - shared constants and types for the reset-request initiator
//
// Purpose: CSR register offsets, the watchdog kick key, CAUSE bit positions
//          and the request FSM state encoding used by m1resetctl.
// Ports:   none (package).
package m1resetctl_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_TIMEOUT = 2'd1;
  localparam logic [1:0] REG_KICK    = 2'd2;
  localparam logic [1:0] REG_CAUSE   = 2'd3;

  localparam logic [31:0] KICK_KEY = 32'h5A5A_A5A5;

  localparam int CAUSE_BTN = 0;
  localparam int CAUSE_SW  = 1;
  localparam int CAUSE_WDT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } req_state_t;

endpackage

// File: rtl/m1resetctl_debounce.sv
// rtl/m1resetctl_debounce.sv - button synchroniser and saturating debounce counter
//
// Purpose: turns a raw asynchronous button level into a single one-cycle
//          request once it has been stable-pressed for debounce_len cycles.
// Ports:   sys_clk  system clock
//          sys_rst  asynchronous active-high reset
//          raw      raw button level, asynchronous to sys_clk
//          pressed  one-cycle pulse when the press is accepted
module m1resetctl_debounce #(
  parameter logic [19:0] debounce_len = 20'd1000000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic raw,
  output logic pressed
);

  localparam logic [19:0] LAST = debounce_len - 20'd1;

  logic        sync_a;
  logic        sync_b;
  logic [19:0] count;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      count   <= '0;
      pressed <= 1'b0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      pressed <= 1'b0;
      if (!sync_b) begin
        count <= '0;
      end else if (count != LAST) begin
        // Pulse coincides with the counter landing on LAST; once there the
        // counter holds, so no repeat until the button is released.
        count   <= count + 20'd1;
        pressed <= (count + 20'd1 == LAST);
      end
    end
  end

endmodule

// File: rtl/m1resetctl.sv
// rtl/m1resetctl.sv - reset-request initiator (button, software, watchdog)
//
// Purpose: merges button, CSR software and watchdog requests into one
//          trigger_reset pulse and records the cause for boot software.
// Ports:   sys_clk        system clock
//          sys_rst        asynchronous active-high reset
//          csr_a/we/di    CSR address, write strobe, write data
//          csr_do         registered CSR read data (0 when bank not selected)
//          btn_reset      raw front-panel button, active-high
//          trigger_reset  reset request to the reset generator
//          wdt_irq        watchdog early-warning interrupt (level)
module m1resetctl
  import m1resetctl_pkg::*;
#(
  parameter logic [3:0]  csr_addr     = 4'h0,
  parameter logic [19:0] debounce_len = 20'd1000000,
  parameter logic [7:0]  pulse_len    = 8'd16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic        btn_reset,
  output logic        trigger_reset,
  output logic        wdt_irq
);

  logic        sel;
  logic        wr;
  logic        btn_req;
  logic        sw_req;
  logic        wdt_req;
  logic        bad_kick;
  logic        good_kick;
  logic        wdt_en;
  logic [31:0] timeout;
  logic [31:0] wdt_count;
  logic [2:0]  req_vec;
  logic        latch_cause;
  logic [7:0]  pulse_cnt;
  logic [7:0]  pulse_cnt_d;
  req_state_t  state;
  req_state_t  state_d;
  logic        unused_addr;

  // Not touched by sys_rst: must survive the reset it reports on.
  logic [2:0]  cause = 3'b000;

  assign sel         = (csr_a[13:10] == csr_addr);
  assign wr          = sel && csr_we;
  assign unused_addr = ^csr_a[9:2];

  assign sw_req    = wr && (csr_a[1:0] == REG_CTRL) && csr_di[1];
  assign good_kick = wr && (csr_a[1:0] == REG_KICK) && (csr_di == KICK_KEY);
  assign bad_kick  = wr && (csr_a[1:0] == REG_KICK) && (csr_di != KICK_KEY);
  assign wdt_req   = (wdt_en && (wdt_count == 32'd0)) || bad_kick;
  assign wdt_irq   = wdt_en && (wdt_count < (timeout >> 2));

  m1resetctl_debounce #(
    .debounce_len(debounce_len)
  ) u_debounce (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .raw    (btn_reset),
    .pressed(btn_req)
  );

  always_comb begin
    req_vec            = 3'b000;
    req_vec[CAUSE_BTN] = btn_req;
    req_vec[CAUSE_SW]  = sw_req;
    req_vec[CAUSE_WDT] = wdt_req;
  end

  // Watchdog and writable registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wdt_en    <= 1'b0;
      timeout   <= '0;
      wdt_count <= '0;
    end else begin
      if (wr && (csr_a[1:0] == REG_TIMEOUT)) timeout <= csr_di;
      if (wr && (csr_a[1:0] == REG_CTRL))    wdt_en  <= csr_di[0];
      if (wr && (csr_a[1:0] == REG_CTRL) && csr_di[0] && !wdt_en) begin
        wdt_count <= timeout;
      end else if (good_kick) begin
        wdt_count <= timeout;
      end else if (wdt_en && (wdt_count != 32'd0)) begin
        wdt_count <= wdt_count - 32'd1;
      end
    end
  end

  always_comb begin
    state_d     = state;
    pulse_cnt_d = pulse_cnt;
    latch_cause = 1'b0;
    case (state)
      IDLE: begin
        if (|req_vec) begin
          latch_cause = 1'b1;
          pulse_cnt_d = pulse_len - 8'd1;
          state_d     = PULSE;
        end
      end
      PULSE: begin
        if (pulse_cnt == 8'd0) state_d = HOLD;
        else                   pulse_cnt_d = pulse_cnt - 8'd1;
      end
      HOLD:    state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= IDLE;
      pulse_cnt     <= '0;
      trigger_reset <= 1'b0;
    end else begin
      state         <= state_d;
      pulse_cnt     <= pulse_cnt_d;
      trigger_reset <= (state_d == PULSE);
    end
  end

  // A newly latched cause wins over a same-cycle clearing write.
  always_ff @(posedge sys_clk) begin
    if (latch_cause) begin
      cause <= req_vec;
    end else if (wr && (csr_a[1:0] == REG_CAUSE)) begin
      cause <= 3'b000;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      csr_do <= '0;
    end else if (!sel) begin
      csr_do <= '0;
    end else begin
      case (csr_a[1:0])
        REG_CTRL:    csr_do <= {31'd0, wdt_en};
        REG_TIMEOUT: csr_do <= timeout;
        REG_KICK:    csr_do <= wdt_count;
        REG_CAUSE:   csr_do <= {29'd0, cause};
        default:     csr_do <= '0;
      endcase
    end
  end

endmodule
